zmod_tx_framer: RTL and testbench
=================================

ZMOD_TX_FRAMER -- requirements
Module: zmod_tx_framer

Interface
REQ-001 Parameter N_LANES, default 3, number of 8-bit data lanes.
REQ-002 Parameter TRAIN_LEN, default 256, training words sent per training burst (range 1..65535).
REQ-003 Parameter FIFO_DEPTH, default 4, input buffer entries (power of two, >=2).
REQ-004 Port clk  input  1  tx divided clock (feeds OSERDES CLKDIV); one clock, all logic on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port retrain  input  1  single-cycle request to restart training.
REQ-007 Port s_data  input  N_LANES*8  input word; byte i goes to lane i.
REQ-008 Port s_valid  input  1  s_data valid.
REQ-009 Port s_ready  output  1  framer accepts s_data this cycle.
REQ-010 Port sync_word  output  8  word for sync lane serializer.
REQ-011 Port dv_word  output  8  word for data-valid strobe lane serializer.
REQ-012 Port lane_data  output  N_LANES*8  words for data lane serializers.
REQ-013 Port train_active  output  1  high while training pattern is on the lanes.
REQ-014 Port word_cnt  output  32  count of user words transmitted, wraps at 2^32.

Function
REQ-015 Transfer occurs on a rising edge where s_valid && s_ready; s_ready = FIFO not full, independent of state.
REQ-016 sync_word shall equal 8'h01 on every cycle after reset deasserts, so the receiver sees one marker bit per 8-bit word.
REQ-017 States: TRAIN, RUN; reset enters TRAIN; TRAIN -> RUN after TRAIN_LEN words emitted; RUN -> TRAIN on retrain.
REQ-018 TRAIN: lane_data every lane = train_cnt[7:0], train_cnt starting at 0 and incrementing by 1 per cycle (wrap 255->0); dv_word = 8'h00; train_active = 1; FIFO not popped.
REQ-019 RUN, FIFO non-empty: pop one word per cycle; lane_data = popped word; dv_word = 8'hFF; word_cnt increments.
REQ-020 RUN, FIFO empty: lane_data = all 8'h00; dv_word = 8'h00 (idle); no error, no count.
REQ-021 All outputs are registered; a word accepted at edge k with FIFO empty in RUN appears on lane_data after edge k+2.
REQ-022 Simultaneous push and pop on a full FIFO shall not be permitted (s_ready low when full); push and pop on a non-full, non-empty FIFO in the same cycle shall both occur.
REQ-023 retrain in TRAIN restarts train_cnt at 0 and the TRAIN_LEN count; retrain in RUN takes effect on the next edge; FIFO contents are retained and resume in order after training.
REQ-024 Word ordering through the FIFO is strictly preserved; no word is dropped or duplicated.

Reset
REQ-025 While reset is high at a rising edge: state TRAIN, train_cnt 0, FIFO empty, s_ready 0, sync_word 8'h00, dv_word 8'h00, lane_data 0, train_active 0, word_cnt 0.
REQ-026 First cycle after reset: s_ready 1, sync_word 8'h01, train_active 1, lane_data 0; reset mid-run flushes the FIFO.

Configuration
REQ-027 Macro ZMOD_TX_PRBS_EN defined: training pattern is PRBS7 (x^7+x^6+1, seed 7'h7F) advanced 8 bits per cycle, lane i using the sequence delayed by i words; undefined: incrementing counter per REQ-018.

Structure
REQ-028 Package zmod_serdes_pkg holds SYNC_WORD 8'h01, DV_ON 8'hFF, DV_OFF 8'h00, IDLE_BYTE 8'h00 and the state enum typedef.
REQ-029 Sub-module zmod_tx_fifo: synchronous FIFO, FIFO_DEPTH entries, N_LANES*8 wide, full/empty flags, synchronous active-high reset.

Verification
REQ-030 Reset release, s_valid 0 -> TRAIN_LEN=256 words 00,01..FF on all lanes, dv 00, then idle 00 with dv 00, sync 01 throughout.
REQ-031 After training, push 24'h030201 once -> two edges later lane_data 24'h030201, dv FF for exactly one cycle, word_cnt 1.
REQ-032 Continuous s_valid with incrementing data for 1000 cycles in RUN -> dv FF every cycle, output sequence identical to input, s_ready never low.
REQ-033 Push 4 words during TRAIN -> s_ready low after 4th; words emerge in order on first 4 RUN cycles.
REQ-034 Pulse retrain mid-stream with 2 words buffered -> next cycle train_cnt 0, train_active 1; after 256 words, buffered words emerge in order.
REQ-035 With ZMOD_TX_PRBS_EN, lane 0 training stream matches a reference PRBS7 model from seed 7'h7F.

Source files
------------

// File: rtl/zmod_serdes_pkg.sv
// Shared constants, state type and PRBS7 helpers for the zmod serdes transmit path.
// The PRBS helpers are used only when ZMOD_TX_PRBS_EN is defined.
package zmod_serdes_pkg;

    localparam logic [7:0] SYNC_WORD = 8'h01;
    localparam logic [7:0] DV_ON     = 8'hFF;
    localparam logic [7:0] DV_OFF    = 8'h00;
    localparam logic [7:0] IDLE_BYTE = 8'h00;
    localparam logic [6:0] PRBS_SEED = 7'h7F;

    typedef enum logic {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } zmod_state_e;

    // x^7 + x^6 + 1, Fibonacci form: the new bit is shifted in at the LSB.
    function automatic logic [6:0] prbs7_adv(input logic [6:0] s, input int unsigned n);
        logic [6:0] st;
        st = s;
        for (int unsigned k = 0; k < n; k++) begin
            st = {st[5:0], st[6] ^ st[5]};
        end
        return st;
    endfunction

    // Next 8 generated bits, first generated bit in bit 7.
    function automatic logic [7:0] prbs7_byte(input logic [6:0] s);
        logic [6:0] st;
        logic [7:0] b;
        st = s;
        b  = '0;
        for (int k = 0; k < 8; k++) begin
            b  = {b[6:0], st[6] ^ st[5]};
            st = {st[5:0], st[6] ^ st[5]};
        end
        return b;
    endfunction

endpackage

// File: rtl/zmod_tx_fifo.sv
// Synchronous FIFO feeding the framer. Written entries become visible to the read
// side one cycle after the write, so the registered framer output lands two edges after acceptance.
module zmod_tx_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_pub;
    logic             do_wr;
    logic             do_rd;

    // full tracks true occupancy; empty only sees writes once wr_pub has caught up.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_pub == rd_ptr);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_pub <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            wr_pub <= wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/zmod_tx_framer.sv
// Transmit framer: training bursts then buffered user words onto N_LANES serializer lanes.
// Define ZMOD_TX_PRBS_EN to train with PRBS7 instead of an incrementing counter.
module zmod_tx_framer
    import zmod_serdes_pkg::*;
#(
    parameter int N_LANES    = 3,
    parameter int TRAIN_LEN  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 retrain,
    input  logic [N_LANES*8-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [7:0]           sync_word,
    output logic [7:0]           dv_word,
    output logic [N_LANES*8-1:0] lane_data,
    output logic                 train_active,
    output logic [31:0]          word_cnt,
    output zmod_state_e          state_dbg
);

    localparam int          W        = N_LANES * 8;
    localparam logic [15:0] LAST_IDX = 16'(TRAIN_LEN - 1);

    zmod_state_e   state_q, state_d;
    logic [15:0]   train_cnt_q, train_cnt_d;
    logic [15:0]   eff_cnt;
    logic          in_train;
    logic          live_q;
    logic [W-1:0]  train_word;

    logic          push;
    logic          pop;
    logic [W-1:0]  fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;

    logic [7:0]    dv_d;
    logic [W-1:0]  lane_d;
    logic          active_d;
    logic [31:0]   word_cnt_d;

    // Handshake: s_data is taken on any rising edge where s_valid && s_ready. s_ready
    // depends only on FIFO occupancy (and is held low in reset), never on the FSM state;
    // the source must keep s_data stable while s_valid is high and s_ready is low.
    assign s_ready   = live_q && !fifo_full;
    assign push      = s_valid && s_ready;
    assign state_dbg = state_q;

    // A retrain pulse behaves like sitting in TRAIN at word 0 on the same edge.
    assign in_train = retrain || (state_q == ST_TRAIN);
    assign eff_cnt  = retrain ? 16'd0 : train_cnt_q;

`ifdef ZMOD_TX_PRBS_EN
    logic [6:0] prbs_q    [N_LANES];
    logic [6:0] prbs_cur  [N_LANES];
    logic [6:0] prbs_init [N_LANES];

    // Lane i runs i words behind lane 0: start it 8*i bits earlier in the 127-bit cycle.
    for (genvar g = 0; g < N_LANES; g++) begin : g_prbs_init
        localparam int unsigned OFS = (127 - ((8 * g) % 127)) % 127;
        assign prbs_init[g] = prbs7_adv(PRBS_SEED, OFS);
    end

    always_comb begin
        train_word = '0;
        for (int i = 0; i < N_LANES; i++) begin
            prbs_cur[i]           = (eff_cnt == 16'd0) ? prbs_init[i] : prbs_q[i];
            train_word[8*i +: 8]  = prbs7_byte(prbs_cur[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_LANES; i++) begin
            if (reset) begin
                prbs_q[i] <= prbs_init[i];
            end else if (in_train) begin
                prbs_q[i] <= prbs7_adv(prbs_cur[i], 8);
            end
        end
    end
`else
    assign train_word = {N_LANES{eff_cnt[7:0]}};
`endif

    zmod_tx_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        pop         = 1'b0;
        dv_d        = DV_OFF;
        lane_d      = {N_LANES{IDLE_BYTE}};
        active_d    = 1'b0;
        word_cnt_d  = word_cnt;
        if (in_train) begin
            active_d = 1'b1;
            lane_d   = train_word;
            if (eff_cnt == LAST_IDX) begin
                state_d     = ST_RUN;
                train_cnt_d = 16'd0;
            end else begin
                state_d     = ST_TRAIN;
                train_cnt_d = eff_cnt + 16'd1;
            end
        end else if (!fifo_empty) begin
            pop        = 1'b1;
            lane_d     = fifo_rd_data;
            dv_d       = DV_ON;
            word_cnt_d = word_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_TRAIN;
            train_cnt_q  <= 16'd0;
            live_q       <= 1'b0;
            sync_word    <= 8'h00;
            dv_word      <= DV_OFF;
            lane_data    <= '0;
            train_active <= 1'b0;
            word_cnt     <= 32'd0;
        end else begin
            state_q      <= state_d;
            train_cnt_q  <= train_cnt_d;
            live_q       <= 1'b1;
            sync_word    <= SYNC_WORD;
            dv_word      <= dv_d;
            lane_data    <= lane_d;
            train_active <= active_d;
            word_cnt     <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_zmod_tx_framer.sv
// Directed bench for zmod_tx_framer; expected training words come from exp_train_word,
// which follows ZMOD_TX_PRBS_EN the same way the design does.
module tb_zmod_tx_framer;
    import zmod_serdes_pkg::*;

    localparam int N_LANES    = 3;
    localparam int TRAIN_LEN  = 256;
    localparam int FIFO_DEPTH = 4;
    localparam int W          = N_LANES * 8;

    logic              txdivclk = 1'b0;
    logic              reset;
    logic              retrain;
    logic [W-1:0]      s_data;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        sync_word;
    logic [7:0]        dv_word;
    logic [W-1:0]      lane_data;
    logic              train_active;
    logic [31:0]       word_cnt;
    zmod_state_e       state_dbg;

    int                check_cnt = 0;
    int                pass_cnt  = 0;
    logic [W-1:0]      exp_q[$];
    logic [31:0]       exp_word_cnt = 32'd0;

    always #5 txdivclk = ~txdivclk;

    zmod_tx_framer #(
        .N_LANES    (N_LANES),
        .TRAIN_LEN  (TRAIN_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (txdivclk),
        .reset        (reset),
        .retrain      (retrain),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .sync_word    (sync_word),
        .dv_word      (dv_word),
        .lane_data    (lane_data),
        .train_active (train_active),
        .word_cnt     (word_cnt),
        .state_dbg    (state_dbg)
    );

    task automatic step();
        @(posedge txdivclk);
        #1;
    endtask

    function automatic logic [W-1:0] exp_train_word(input int idx);
        logic [W-1:0] w;
        w = '0;
`ifdef ZMOD_TX_PRBS_EN
        begin
            logic       bits [127];
            logic [6:0] s;
            int         p;
            s = 7'h7F;
            for (int n = 0; n < 127; n++) begin
                bits[n] = s[6] ^ s[5];
                s       = {s[5:0], bits[n]};
            end
            for (int i = 0; i < N_LANES; i++) begin
                p = (((8 * idx - 8 * i) % 127) + 127) % 127;
                for (int k = 0; k < 8; k++) begin
                    w[8*i + 7 - k] = bits[(p + k) % 127];
                end
            end
        end
`else
        for (int i = 0; i < N_LANES; i++) begin
            w[8*i +: 8] = 8'(idx);
        end
`endif
        return w;
    endfunction

    task automatic test_reset();
        reset   = 1'b1;
        retrain = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) step();
        check_cnt++;
        if ({sync_word, dv_word, lane_data, train_active} !== '0)
            $display("FAIL reset_outputs: got sync=%h dv=%h lane=%h act=%b, want all zero",
                     sync_word, dv_word, lane_data, train_active);
        else pass_cnt++;
        check_cnt++;
        if (s_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", s_ready);
        else pass_cnt++;
        check_cnt++;
        if (word_cnt !== 32'd0) $display("FAIL reset_word_cnt: got %0d want 0", word_cnt);
        else pass_cnt++;
        check_cnt++;
        if (state_dbg !== ST_TRAIN) $display("FAIL reset_state: got %0d want TRAIN", state_dbg);
        else pass_cnt++;

        reset = 1'b0;
        step();
        check_cnt++;
        if ({s_ready, sync_word, dv_word, train_active, lane_data} !==
            {1'b1, 8'h01, 8'h00, 1'b1, exp_train_word(0)})
            $display("FAIL first_cycle: got rdy=%b sync=%h dv=%h act=%b lane=%h, want 1 01 00 1 %h",
                     s_ready, sync_word, dv_word, train_active, lane_data, exp_train_word(0));
        else pass_cnt++;
    endtask

    task automatic test_training();
        for (int idx = 1; idx < TRAIN_LEN; idx++) begin
            step();
            check_cnt++;
            if ({sync_word, dv_word, train_active, lane_data} !== {8'h01, 8'h00, 1'b1, exp_train_word(idx)})
                $display("FAIL train_word[%0d]: got sync=%h dv=%h act=%b lane=%h, want 01 00 1 %h",
                         idx, sync_word, dv_word, train_active, lane_data, exp_train_word(idx));
            else pass_cnt++;
        end
        repeat (4) begin
            step();
            check_cnt++;
            if ({sync_word, dv_word, train_active, lane_data} !== {8'h01, 8'h00, 1'b0, {W{1'b0}}})
                $display("FAIL idle_after_train: got sync=%h dv=%h act=%b lane=%h, want 01 00 0 0",
                         sync_word, dv_word, train_active, lane_data);
            else pass_cnt++;
        end
        check_cnt++;
        if ({state_dbg, word_cnt} !== {ST_RUN, 32'd0})
            $display("FAIL run_entry: got state=%0d cnt=%0d, want RUN 0", state_dbg, word_cnt);
        else pass_cnt++;
    endtask

    task automatic test_single_word();
        s_data  = 24'h030201;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        s_data  = '0;
        for (int e = 0; e < 2; e++) begin
            check_cnt++;
            if ({dv_word, lane_data} !== {8'h00, {W{1'b0}}})
                $display("FAIL single_early[%0d]: got dv=%h lane=%h, want 00 0", e, dv_word, lane_data);
            else pass_cnt++;
            if (e == 0) step();
        end
        step();
        exp_word_cnt = 32'd1;
        check_cnt++;
        if ({dv_word, lane_data, word_cnt} !== {8'hFF, 24'h030201, exp_word_cnt})
            $display("FAIL single_word: got dv=%h lane=%h cnt=%0d, want ff 030201 1",
                     dv_word, lane_data, word_cnt);
        else pass_cnt++;
        step();
        check_cnt++;
        if ({dv_word, lane_data} !== {8'h00, {W{1'b0}}})
            $display("FAIL single_one_cycle: got dv=%h lane=%h, want 00 0", dv_word, lane_data);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [W-1:0] e;
        int           accepted;
        accepted = 0;
        for (int i = 0; i < 1000; i++) begin
            check_cnt++;
            if (s_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", i, s_ready);
            else pass_cnt++;
            s_data  = W'(32'h00C000 + 32'(i) * 32'd7);
            s_valid = 1'b1;
            if (s_ready === 1'b1) begin
                exp_q.push_back(s_data);
                accepted++;
            end
            step();
            if (i >= 2) begin
                check_cnt++;
                if (dv_word !== DV_ON) $display("FAIL stream_dv[%0d]: got %h want ff", i, dv_word);
                else pass_cnt++;
            end
            if (dv_word === DV_ON) begin
                check_cnt++;
                if (exp_q.size() == 0) $display("FAIL stream_extra: got lane=%h want no word", lane_data);
                else begin
                    e = exp_q.pop_front();
                    if (lane_data !== e) $display("FAIL stream_data: got %h want %h", lane_data, e);
                    else pass_cnt++;
                end
            end
        end
        s_valid = 1'b0;
        repeat (6) begin
            step();
            if (dv_word === DV_ON) begin
                check_cnt++;
                if (exp_q.size() == 0) $display("FAIL drain_extra: got lane=%h want no word", lane_data);
                else begin
                    e = exp_q.pop_front();
                    if (lane_data !== e) $display("FAIL drain_data: got %h want %h", lane_data, e);
                    else pass_cnt++;
                end
            end
        end
        exp_word_cnt = exp_word_cnt + 32'(accepted);
        check_cnt++;
        if (exp_q.size() != 0) $display("FAIL stream_lost: got %0d words left want 0", exp_q.size());
        else pass_cnt++;
        check_cnt++;
        if (word_cnt !== 32'd1001) $display("FAIL stream_word_cnt: got %0d want 1001", word_cnt);
        else pass_cnt++;
    endtask

    task automatic test_fill_during_train();
        logic [W-1:0] e;
        int           idx;
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        idx = 0;
        check_cnt++;
        if ({state_dbg, train_active, dv_word, lane_data} !== {ST_TRAIN, 1'b1, 8'h00, exp_train_word(0)})
            $display("FAIL retrain_run: got st=%0d act=%b dv=%h lane=%h, want TRAIN 1 00 %h",
                     state_dbg, train_active, dv_word, lane_data, exp_train_word(0));
        else pass_cnt++;
        for (int j = 0; j < 4; j++) begin
            check_cnt++;
            if (s_ready !== 1'b1) $display("FAIL fill_ready[%0d]: got %b want 1", j, s_ready);
            else pass_cnt++;
            s_data  = W'(32'hA0A0A0 + 32'(j));
            s_valid = 1'b1;
            exp_q.push_back(s_data);
            step();
            idx++;
        end
        s_data = 24'hBADBAD;
        for (int k = 0; k < 3; k++) begin
            check_cnt++;
            if ({s_ready, train_active, lane_data} !== {1'b0, 1'b1, exp_train_word(idx)})
                $display("FAIL fill_full[%0d]: got rdy=%b act=%b lane=%h, want 0 1 %h",
                         k, s_ready, train_active, lane_data, exp_train_word(idx));
            else pass_cnt++;
            step();
            idx++;
        end
        s_valid = 1'b0;
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        check_cnt++;
        if ({train_active, lane_data} !== {1'b1, exp_train_word(0)})
            $display("FAIL retrain_in_train: got act=%b lane=%h, want 1 %h",
                     train_active, lane_data, exp_train_word(0));
        else pass_cnt++;
        for (int t = 1; t < TRAIN_LEN; t++) begin
            step();
            check_cnt++;
            if ({train_active, dv_word, lane_data} !== {1'b1, 8'h00, exp_train_word(t)})
                $display("FAIL fill_train[%0d]: got act=%b dv=%h lane=%h, want 1 00 %h",
                         t, train_active, dv_word, lane_data, exp_train_word(t));
            else pass_cnt++;
        end
        for (int j = 0; j < 4; j++) begin
            step();
            e = exp_q.pop_front();
            check_cnt++;
            if ({dv_word, lane_data} !== {8'hFF, e})
                $display("FAIL fill_out[%0d]: got dv=%h lane=%h, want ff %h", j, dv_word, lane_data, e);
            else pass_cnt++;
        end
        step();
        exp_word_cnt = exp_word_cnt + 32'd4;
        check_cnt++;
        if ({dv_word, s_ready, word_cnt} !== {8'h00, 1'b1, exp_word_cnt})
            $display("FAIL fill_done: got dv=%h rdy=%b cnt=%0d, want 00 1 %0d",
                     dv_word, s_ready, word_cnt, exp_word_cnt);
        else pass_cnt++;
    endtask

    task automatic test_retrain_midstream();
        logic [W-1:0] e;
        s_valid = 1'b1;
        s_data  = 24'h111111;
        exp_q.push_back(s_data);
        step();
        s_data  = 24'h222222;
        exp_q.push_back(s_data);
        step();
        s_valid = 1'b0;
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        check_cnt++;
        if ({state_dbg, train_active, dv_word, lane_data} !== {ST_TRAIN, 1'b1, 8'h00, exp_train_word(0)})
            $display("FAIL midstream_retrain: got st=%0d act=%b dv=%h lane=%h, want TRAIN 1 00 %h",
                     state_dbg, train_active, dv_word, lane_data, exp_train_word(0));
        else pass_cnt++;
        for (int t = 1; t < TRAIN_LEN; t++) begin
            step();
            check_cnt++;
            if ({train_active, dv_word, lane_data} !== {1'b1, 8'h00, exp_train_word(t)})
                $display("FAIL midstream_train[%0d]: got act=%b dv=%h lane=%h, want 1 00 %h",
                         t, train_active, dv_word, lane_data, exp_train_word(t));
            else pass_cnt++;
        end
        for (int j = 0; j < 2; j++) begin
            step();
            e = exp_q.pop_front();
            check_cnt++;
            if ({dv_word, lane_data} !== {8'hFF, e})
                $display("FAIL midstream_out[%0d]: got dv=%h lane=%h, want ff %h", j, dv_word, lane_data, e);
            else pass_cnt++;
        end
        step();
        exp_word_cnt = exp_word_cnt + 32'd2;
        check_cnt++;
        if ({dv_word, lane_data, word_cnt} !== {8'h00, {W{1'b0}}, exp_word_cnt})
            $display("FAIL midstream_done: got dv=%h lane=%h cnt=%0d, want 00 0 %0d",
                     dv_word, lane_data, word_cnt, exp_word_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_flush();
        s_valid = 1'b1;
        s_data  = 24'h5A5A5A;
        step();
        s_data  = 24'hA5A5A5;
        step();
        s_valid = 1'b0;
        reset   = 1'b1;
        step();
        exp_word_cnt = 32'd0;
        check_cnt++;
        if ({s_ready, sync_word, dv_word, train_active, lane_data, word_cnt} !== '0)
            $display("FAIL flush_reset: got rdy=%b sync=%h dv=%h act=%b lane=%h cnt=%0d, want all zero",
                     s_ready, sync_word, dv_word, train_active, lane_data, word_cnt);
        else pass_cnt++;
        reset = 1'b0;
        for (int t = 0; t < TRAIN_LEN; t++) begin
            step();
            check_cnt++;
            if ({train_active, lane_data} !== {1'b1, exp_train_word(t)})
                $display("FAIL flush_train[%0d]: got act=%b lane=%h, want 1 %h",
                         t, train_active, lane_data, exp_train_word(t));
            else pass_cnt++;
        end
        repeat (5) begin
            step();
            check_cnt++;
            if ({dv_word, lane_data, word_cnt} !== {8'h00, {W{1'b0}}, exp_word_cnt})
                $display("FAIL flush_idle: got dv=%h lane=%h cnt=%0d, want 00 0 0",
                         dv_word, lane_data, word_cnt);
            else pass_cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_training();
        test_single_word();
        test_stream();
        test_fill_during_train();
        test_retrain_midstream();
        test_reset_flush();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
